// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// the responder state encoding and the access-legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DATA
    } state_t;

    // Any code outside B/H/W/BU/HU is illegal; halves need even and words need 4-byte alignment.
    function automatic logic access_fault(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_B, F3_BU: access_fault = 1'b0;
            F3_H, F3_HU: access_fault = offset[0];
            F3_W:        access_fault = (offset != 2'b00);
            default:     access_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a RAM read word and sign- or
// zero-extends it according to the load's funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'h000000, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_load_responder.sv
// Memory-side load/store responder: drives a fixed-latency data RAM, stalls the
// core while a load is in flight and returns formatted load data for writeback.
module lsu_load_responder
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_lsu_valid,
    input  logic              i_lsu_wren,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_st_data,
    output logic              o_stall,
    output logic              o_ld_valid,
    output logic [31:0]       o_ld_data,
    output logic              o_fault,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  count;
    logic [2:0]  count_next;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        req_fault;
    logic        load_issue;
    logic [31:0] aligned;
    logic        unused_addr_bits;

    assign req_fault        = access_fault(i_funct3, i_addr[1:0]);
    assign load_issue       = (state == IDLE) && i_lsu_valid && !i_lsu_wren && !req_fault;
    assign unused_addr_bits = ^i_addr[31:ADDR_W+2];

    lsu_load_align u_align (
        .rdata  (i_mem_rdata),
        .funct3 (ld_funct3),
        .offset (ld_offset),
        .data   (aligned)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            count     <= '0;
            ld_funct3 <= '0;
            ld_offset <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (load_issue) begin
                ld_funct3 <= i_funct3;
                ld_offset <= i_addr[1:0];
            end
        end
    end

    // IDLE responses are combinational so stores and faults complete in the request cycle.
    always_comb begin
        state_next  = state;
        count_next  = count;
        o_stall     = 1'b0;
        o_ld_valid  = 1'b0;
        o_ld_data   = '0;
        o_fault     = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'b0000;
        o_mem_addr  = '0;
        o_mem_wdata = '0;

        case (state)
            IDLE: begin
                if (i_lsu_valid) begin
                    if (req_fault) begin
                        o_fault = 1'b1;
                    end else if (i_lsu_wren) begin
                        o_mem_req  = 1'b1;
                        o_mem_we   = 1'b1;
                        o_mem_addr = i_addr[ADDR_W+1:2];
                        case (i_funct3[1:0])
                            2'b00: begin
                                o_mem_be    = 4'b0001 << i_addr[1:0];
                                o_mem_wdata = {4{i_st_data[7:0]}};
                            end
                            2'b01: begin
                                o_mem_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                                o_mem_wdata = {2{i_st_data[15:0]}};
                            end
                            default: begin
                                o_mem_be    = 4'b1111;
                                o_mem_wdata = i_st_data;
                            end
                        endcase
                    end else begin
                        o_mem_req  = 1'b1;
                        o_mem_be   = 4'b1111;
                        o_mem_addr = i_addr[ADDR_W+1:2];
                        o_stall    = 1'b1;
                        if (MEM_LAT > 1) begin
                            state_next = WAIT;
                            count_next = 3'(MEM_LAT - 1);
                        end else begin
                            state_next = DATA;
                        end
                    end
                end
            end
            WAIT: begin
                o_stall = 1'b1;
                if (count <= 3'd1) begin
                    state_next = DATA;
                    count_next = '0;
                end else begin
                    count_next = count - 3'd1;
                end
            end
            DATA: begin
                o_ld_valid = 1'b1;
                o_ld_data  = aligned;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset forces every output low immediately, including the combinational IDLE paths.
        if (!i_reset) begin
            o_stall     = 1'b0;
            o_ld_valid  = 1'b0;
            o_ld_data   = '0;
            o_fault     = 1'b0;
            o_mem_req   = 1'b0;
            o_mem_we    = 1'b0;
            o_mem_be    = 4'b0000;
            o_mem_addr  = '0;
            o_mem_wdata = '0;
        end
    end

endmodule
